// File: rtl/uart_rx_ex_if.sv
// uart_rx_ex_if: word stream plus per-word status flags from the UART receiver to its consumer.
interface uart_rx_ex_if #(parameter int DATA_WIDTH = 8);
    logic [DATA_WIDTH-1:0] data;
    logic data_valid;
    logic data_ready;
    logic parity_error;
    logic framing_error;
    logic break_detect;
    logic overrun;
    modport master (output data, data_valid, parity_error, framing_error, break_detect, overrun, input data_ready);
    modport slave (input data, data_valid, parity_error, framing_error, break_detect, overrun, output data_ready);
endinterface

// File: rtl/uart_rx_ex.sv
// uart_rx_ex: parametrised oversampling UART receiver with parity/framing/break/overrun reporting.
// Define UART_RX_MAJORITY_EN to take a 2-of-3 majority vote at every sample point.
module uart_rx_ex #(
    parameter int DATA_WIDTH  = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_TYPE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic rx,
    uart_rx_ex_if.master m
);
    localparam int CW = $clog2(OVERSAMPLE) + 1;
    localparam int HALF = OVERSAMPLE / 2;
    localparam bit HAS_PAR = PARITY_TYPE != 0;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, COMPLETE, BREAK_WAIT} state_t;
    state_t state;
    logic [1:0] sync;
    logic rx_s, bit_in, tick, done, perr, fe_n, bk_n;
    logic [CW-1:0] cnt;
    logic [3:0] idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic xacc, par_s, ferr, brk;
    assign rx_s = sync[1];
    always_ff @(posedge clock) sync <= reset ? 2'b11 : {sync[0], rx};
`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist;
    always_ff @(posedge clock) hist <= reset ? 2'b11 : {hist[0], rx_s};
    assign bit_in = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
    assign bit_in = rx_s;
`endif
    assign tick = cnt == CW'(OVERSAMPLE - 1);
    assign done = state == STOP && tick && idx == 4'(STOP_BITS - 1);
    assign perr = (PARITY_TYPE == 1) ? (par_s != xacc) :
                  (PARITY_TYPE == 2) ? (par_s == xacc) :
                  (PARITY_TYPE == 3) ? !par_s :
                  (PARITY_TYPE == 4) && par_s;
    // Stop-bit and break status include the sample being taken this very cycle.
    assign fe_n = ferr | ~bit_in;
    assign bk_n = shreg == '0 && (!HAS_PAR || !par_s) && fe_n;
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            idx <= '0;
            shreg <= '0;
            xacc <= 1'b0;
            par_s <= 1'b0;
            ferr <= 1'b0;
            brk <= 1'b0;
            m.data <= '0;
            m.data_valid <= 1'b0;
            m.parity_error <= 1'b0;
            m.framing_error <= 1'b0;
            m.break_detect <= 1'b0;
            m.overrun <= 1'b0;
        end else begin
            if (m.data_valid && m.data_ready) begin
                m.data_valid <= 1'b0;
                m.overrun <= 1'b0;
            end
            if (done && (!m.data_valid || m.data_ready)) begin
                m.data <= shreg;
                m.data_valid <= 1'b1;
                m.parity_error <= perr;
                m.framing_error <= fe_n;
                m.break_detect <= bk_n;
            end else if (done) begin
                m.overrun <= 1'b1;
            end
            case (state)
                IDLE: if (!bit_in) begin
                    cnt <= CW'(1);
                    state <= START;
                end
                START: if (bit_in) begin
                    state <= IDLE;
                end else if (cnt == CW'(HALF - 1)) begin
                    cnt <= '0;
                    idx <= '0;
                    xacc <= 1'b0;
                    ferr <= 1'b0;
                    par_s <= 1'b0;
                    state <= DATA;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                DATA: if (tick) begin
                    cnt <= '0;
                    shreg <= {bit_in, shreg[DATA_WIDTH-1:1]};
                    xacc <= xacc ^ bit_in;
                    idx <= idx == 4'(DATA_WIDTH - 1) ? 4'd0 : idx + 4'd1;
                    if (idx == 4'(DATA_WIDTH - 1)) state <= HAS_PAR ? PARITY : STOP;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                PARITY: if (tick) begin
                    cnt <= '0;
                    par_s <= bit_in;
                    state <= STOP;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                STOP: if (tick) begin
                    cnt <= '0;
                    ferr <= fe_n;
                    brk <= bk_n;
                    idx <= done ? 4'd0 : idx + 4'd1;
                    if (done) state <= COMPLETE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                // A break keeps the line low; hold off new starts until it idles.
                COMPLETE: state <= brk ? BREAK_WAIT : IDLE;
                BREAK_WAIT: if (bit_in) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_ex.sv
// tb_uart_rx_ex: directed and randomized frames on an 8N1/16x receiver and an 8E2/8x receiver.
module tb_uart_rx_ex;
    typedef struct packed {
        logic [7:0] d;
        logic pe;
        logic fe;
        logic bk;
        logic ov;
    } rec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic rx0 = 1'b1;
    logic rx1 = 1'b1;
    int n_cmp = 0;
    int n_err = 0;
    int n;
    int lat_exp;
    logic [15:0] fb;
    rec_t q0[$];
    rec_t q1[$];

    always #5 clock = ~clock;

    uart_rx_ex_if #(.DATA_WIDTH(8)) if0 ();
    uart_rx_ex_if #(.DATA_WIDTH(8)) if1 ();

    uart_rx_ex #(.DATA_WIDTH(8), .OVERSAMPLE(16), .PARITY_TYPE(0), .STOP_BITS(1)) u0 (
        .clock(clock), .reset(reset), .rx(rx0), .m(if0));
    uart_rx_ex #(.DATA_WIDTH(8), .OVERSAMPLE(8), .PARITY_TYPE(1), .STOP_BITS(2)) u1 (
        .clock(clock), .reset(reset), .rx(rx1), .m(if1));

    always @(negedge clock) begin
        if (if0.data_valid && if0.data_ready)
            q0.push_back(rec_t'({if0.data, if0.parity_error, if0.framing_error, if0.break_detect, if0.overrun}));
        if (if1.data_valid && if1.data_ready)
            q1.push_back(rec_t'({if1.data, if1.parity_error, if1.framing_error, if1.break_detect, if1.overrun}));
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] f0(input logic [7:0] d, input logic s);
        return {6'b0, s, d, 1'b0};
    endfunction

    function automatic logic [15:0] f1(input logic [7:0] d, input logic p, input logic s1, input logic s2);
        return {4'b0, s2, s1, p, d, 1'b0};
    endfunction

    function automatic rec_t m0(input logic [15:0] b, input logic ov);
        rec_t r;
        r.d = b[8:1];
        r.pe = 1'b0;
        r.fe = !b[9];
        r.bk = (b[8:1] == 8'h00) && r.fe;
        r.ov = ov;
        return r;
    endfunction

    function automatic rec_t m1(input logic [15:0] b, input logic ov);
        rec_t r;
        r.d = b[8:1];
        r.pe = b[9] != ^b[8:1];
        r.fe = !(b[10] && b[11]);
        r.bk = (b[9:1] == 9'h000) && r.fe;
        r.ov = ov;
        return r;
    endfunction

    function automatic int qs(input int line);
        return line == 0 ? q0.size() : q1.size();
    endfunction

    task automatic send(input int line, input logic [15:0] bits, input int nb, input int os);
        for (int i = 0; i < nb; i++) begin
            if (line == 0) rx0 = bits[i]; else rx1 = bits[i];
            repeat (os) @(posedge clock);
            #1;
        end
        if (line == 0) rx0 = 1'b1; else rx1 = 1'b1;
        repeat (os) @(posedge clock);
        #1;
    endtask

    task automatic expect_word(input int line, input rec_t exp, input string tag);
        rec_t r;
        int t = 0;
        while (qs(line) == 0 && t < 400) begin
            @(posedge clock);
            #1;
            t++;
        end
        chk({tag, "_present"}, 32'(qs(line) != 0), 32'd1);
        if (qs(line) != 0) begin
            if (line == 0) r = q0.pop_front(); else r = q1.pop_front();
            chk(tag, 32'(r), 32'(exp));
        end
    endtask

    initial begin
        if0.data_ready = 1'b1;
        if1.data_ready = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        chk("reset_u0", 32'({if0.data, if0.data_valid, if0.parity_error, if0.framing_error, if0.break_detect, if0.overrun}), 32'd0);
        chk("reset_u1", 32'({if1.data, if1.data_valid, if1.parity_error, if1.framing_error, if1.break_detect, if1.overrun}), 32'd0);
        reset = 1'b0;
        repeat (5) @(posedge clock);
        #1;

        // Latency from the rx falling edge: 2 sync flops + half a bit + 9 further bit times.
        lat_exp = 2 + 16 / 2 + 9 * 16;
`ifdef UART_RX_MAJORITY_EN
        lat_exp = lat_exp + 1;
`endif
        n = 0;
        fork
            send(0, f0(8'hA5, 1'b1), 10, 16);
            begin
                while (!if0.data_valid && n < 400) begin
                    @(posedge clock);
                    #1;
                    n++;
                end
                chk("latency", 32'(n), 32'(lat_exp));
                @(posedge clock);
                #1;
                chk("valid_pulse", 32'(if0.data_valid), 32'd0);
            end
        join
        expect_word(0, m0(f0(8'hA5, 1'b1), 1'b0), "a5");

        send(1, f1(8'h03, 1'b1, 1'b1, 1'b1), 12, 8);
        expect_word(1, m1(f1(8'h03, 1'b1, 1'b1, 1'b1), 1'b0), "par_bad");
        send(1, f1(8'h03, 1'b0, 1'b1, 1'b1), 12, 8);
        expect_word(1, m1(f1(8'h03, 1'b0, 1'b1, 1'b1), 1'b0), "par_good");

        send(0, f0(8'h5A, 1'b0), 10, 16);
        expect_word(0, m0(f0(8'h5A, 1'b0), 1'b0), "framing");
        send(0, f0(8'h11, 1'b1), 10, 16);
        expect_word(0, m0(f0(8'h11, 1'b1), 1'b0), "after_framing");

        for (int i = 0; i < 8; i++) begin
            fb = f0(8'($urandom_range(0, 255)), 1'b1);
            send(0, fb, 10, 16);
            expect_word(0, m0(fb, 1'b0), "rand_u0");
        end
        for (int i = 0; i < 8; i++) begin
            fb = f1(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            send(1, fb, 12, 8);
            expect_word(1, m1(fb, 1'b0), "rand_u1");
        end

        if0.data_ready = 1'b0;
        send(0, f0(8'h11, 1'b1), 10, 16);
        send(0, f0(8'h22, 1'b1), 10, 16);
        chk("ovr_hold", 32'({if0.data, if0.data_valid, if0.overrun}), 32'({8'h11, 1'b1, 1'b1}));
        chk("ovr_no_handshake", 32'(q0.size()), 32'd0);
        if0.data_ready = 1'b1;
        @(posedge clock);
        #1;
        chk("ovr_clear", 32'({if0.data_valid, if0.overrun}), 32'd0);
        expect_word(0, m0(f0(8'h11, 1'b1), 1'b1), "ovr_word");

        rx0 = 1'b0;
        repeat (3 * 16 * 10) @(posedge clock);
        #1;
        rx0 = 1'b1;
        expect_word(0, m0(16'h0000, 1'b0), "break");
        repeat (200) @(posedge clock);
        #1;
        chk("break_single", 32'(q0.size()), 32'd0);

        rx0 = 1'b0;
        repeat (16 / 2 - 1) @(posedge clock);
        #1;
        rx0 = 1'b1;
        repeat (200) @(posedge clock);
        #1;
        chk("glitch_reject", 32'({q0.size() != 0, if0.data_valid}), 32'd0);

        fork
            send(0, f0(8'hFF, 1'b1), 10, 16);
            begin
                repeat (16 / 2 - 1 + 4 * 16) @(posedge clock);
                #1;
                rx0 = 1'b0;
                @(posedge clock);
                #1;
                rx0 = 1'b1;
            end
        join
`ifdef UART_RX_MAJORITY_EN
        expect_word(0, m0(f0(8'hFF, 1'b1), 1'b0), "bit3_glitch");
`else
        expect_word(0, m0(f0(8'hF7, 1'b1), 1'b0), "bit3_glitch");
`endif

        if0.data_ready = 1'b0;
        send(0, f0(8'h77, 1'b1), 10, 16);
        chk("pending_before_reset", 32'(if0.data_valid), 32'd1);
        rx0 = 1'b0;
        repeat (40) @(posedge clock);
        #1;
        reset = 1'b1;
        rx0 = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("midframe_reset", 32'({if0.data, if0.data_valid, if0.parity_error, if0.framing_error, if0.break_detect, if0.overrun}), 32'd0);
        reset = 1'b0;
        if0.data_ready = 1'b1;
        repeat (200) @(posedge clock);
        #1;
        chk("reset_no_word", 32'(q0.size()), 32'd0);
        send(0, f0(8'h3C, 1'b1), 10, 16);
        expect_word(0, m0(f0(8'h3C, 1'b1), 1'b0), "after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
